// File: rtl/ps2_keycode_rx_if.sv
// Keycode bus shared between the PS/2 receiver (master) and the game control FSMs (slaves).
interface ps2_keycode_rx_if;
    logic [15:0] keycode;
    logic        key_valid;
    logic        frame_err;

    modport master (
        output keycode,
        output key_valid,
        output frame_err
    );

    modport slave (
        input keycode,
        input key_valid,
        input frame_err
    );
endinterface

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver: conditions the raw PS/2 lines, frames bytes,
// tracks E0/F0 prefixes and reports the held game key as a USB-HID usage code.
module ps2_keycode_rx #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TIMEOUT_US  = 2000,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    ps2_keycode_rx_if.master   kbd
);

    localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TO_W   = $clog2(TO_CYC + 1);
    localparam int FL_W   = $clog2(FILTER_LEN + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    // Odd parity check over eight data bits plus the received parity bit.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Scan-code (set 2) to HID usage translation for the game keys; 0 = unmapped.
    function automatic logic [7:0] hid_map(input logic ext, input logic [7:0] b);
        logic [7:0] u;
        u = 8'h00;
        if (ext) begin
            case (b)
                8'h75:   u = 8'h52;
                8'h6B:   u = 8'h50;
                8'h72:   u = 8'h51;
                8'h74:   u = 8'h4F;
                default: u = 8'h00;
            endcase
        end else begin
            case (b)
                8'h1D:   u = 8'h1A;
                8'h1C:   u = 8'h04;
                8'h1B:   u = 8'h16;
                8'h23:   u = 8'h07;
                8'h29:   u = 8'h2C;
                8'h5A:   u = 8'h28;
                8'h76:   u = 8'h29;
                8'h4D:   u = 8'h13;
                default: u = 8'h00;
            endcase
        end
        return u;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic [FL_W-1:0]        filt_cnt_r;
    logic                   filt_clk_r;
    logic                   filt_prev_r;
    logic [1:0]             state_r;
    logic [2:0]             bit_cnt_r;
    logic [7:0]             shift_r;
    logic                   par_ok_r;
    logic [TO_W-1:0]        to_cnt_r;
    logic                   ext_r;
    logic                   brk_r;
    logic [15:0]            keycode_r;
    logic                   key_valid_r;
    logic                   frame_err_r;

    logic                   clk_s;
    logic                   data_s;
    logic                   fall_s;
    logic                   byte_ok_s;
    logic                   frame_bad_s;
    logic                   timeout_s;
    logic [7:0]             map_u_s;

    assign clk_s  = clk_sync_r[SYNC_STAGES-1];
    assign data_s = data_sync_r[SYNC_STAGES-1];
    assign fall_s = filt_prev_r & ~filt_clk_r;

    assign kbd.keycode   = keycode_r;
    assign kbd.key_valid = key_valid_r;
    assign kbd.frame_err = frame_err_r;

    // Synchronise both asynchronous PS/2 lines; idle level is high.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            filt_cnt_r  <= {FL_W{1'b0}};
            filt_clk_r  <= 1'b1;
            filt_prev_r <= 1'b1;
        end else begin
            filt_prev_r <= filt_clk_r;
            if (clk_s == filt_clk_r) begin
                filt_cnt_r <= {FL_W{1'b0}};
            end else if (filt_cnt_r == FL_W'(FILTER_LEN - 1)) begin
                filt_clk_r <= clk_s;
                filt_cnt_r <= {FL_W{1'b0}};
            end else begin
                filt_cnt_r <= filt_cnt_r + FL_W'(1);
            end
        end
    end

    // Classify the current cycle: accepted byte, bad stop/parity, or inter-edge timeout.
    always_comb begin
        byte_ok_s   = 1'b0;
        frame_bad_s = 1'b0;
        timeout_s   = 1'b0;
        map_u_s     = hid_map(ext_r, shift_r);
        if (fall_s && (state_r == ST_STOP)) begin
            if (data_s && par_ok_r) begin
                byte_ok_s = 1'b1;
            end else begin
                frame_bad_s = 1'b1;
            end
        end else if ((state_r != ST_IDLE) && !fall_s && (to_cnt_r == TO_W'(TO_CYC - 1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Frame FSM: one transition per PS/2 clock fall, watchdog inside a frame.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            par_ok_r  <= 1'b0;
            to_cnt_r  <= {TO_W{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) || fall_s) begin
                to_cnt_r <= {TO_W{1'b0}};
            end else begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end

            if (timeout_s) begin
                state_r <= ST_IDLE;
            end else if (fall_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shift_r   <= {data_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_PARITY: begin
                        par_ok_r <= parity_ok(shift_r, data_s);
                        state_r  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    // Byte decode: prefix tracking, make/break handling and registered output pulses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ext_r       <= 1'b0;
            brk_r       <= 1'b0;
            keycode_r   <= 16'h0000;
            key_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            key_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            if (frame_bad_s || timeout_s) begin
                frame_err_r <= 1'b1;
                ext_r       <= 1'b0;
                brk_r       <= 1'b0;
            end else if (byte_ok_s) begin
                if (shift_r == BYTE_EXT) begin
                    ext_r <= 1'b1;
                end else if (shift_r == BYTE_BRK) begin
                    brk_r <= 1'b1;
                end else begin
                    ext_r <= 1'b0;
                    brk_r <= 1'b0;
                    if (map_u_s == 8'h00) begin
                        key_valid_r <= 1'b0;
                    end else if (!brk_r) begin
                        // Typematic repeats of the held key are silent.
                        if (keycode_r != {8'h00, map_u_s}) begin
                            keycode_r   <= {8'h00, map_u_s};
                            key_valid_r <= 1'b1;
                        end else begin
                            key_valid_r <= 1'b0;
                        end
                    end else begin
                        // Only the release of the reported key clears it.
                        if (keycode_r[7:0] == map_u_s) begin
                            keycode_r   <= 16'h0000;
                            key_valid_r <= 1'b1;
                        end else begin
                            key_valid_r <= 1'b0;
                        end
                    end
                end
            end else begin
                keycode_r <= keycode_r;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: bit-banged PS/2 frames, key_valid
// pulses checked against a queue of expected keycodes.
module tb_ps2_keycode_rx;

    localparam int TO_CYC = 200;
    localparam int HALF   = 20;

    logic Clk;
    logic Reset;
    logic ps2_clk;
    logic ps2_data;

    ps2_keycode_rx_if kbd ();

    ps2_keycode_rx #(
        .CLK_HZ      (1_000_000),
        .TIMEOUT_US  (TO_CYC),
        .SYNC_STAGES (2),
        .FILTER_LEN  (8)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .kbd      (kbd.master)
    );

    int          n_total;
    int          n_bad;
    int          err_seen;
    int          err_exp;
    logic [15:0] sb[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: pops the scoreboard on every key_valid pulse.
    always @(negedge Clk) begin
        logic [15:0] e;
        if (Reset) begin
            check("vld_err_excl", {31'd0, kbd.key_valid & kbd.frame_err}, 32'd0);
            if (kbd.key_valid) begin
                check("valid_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("keycode_pulse", {16'd0, kbd.keycode}, {16'd0, e});
                end
            end
            if (kbd.frame_err) err_seen++;
        end
    end

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        repeat (HALF) @(posedge Clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(posedge Clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (30) @(posedge Clk);
    endtask

    task automatic step_done(input string tag, input logic [15:0] kc);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
        check({tag, "_keycode"}, {16'd0, kbd.keycode}, {16'd0, kc});
        check({tag, "_errs"}, err_seen, err_exp);
    endtask

    initial begin
        n_total  = 0;
        n_bad    = 0;
        err_seen = 0;
        err_exp  = 0;
        Reset    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        check("rst_keycode", {16'd0, kbd.keycode}, 32'd0);
        check("rst_valid", {31'd0, kbd.key_valid}, 32'd0);
        check("rst_err", {31'd0, kbd.frame_err}, 32'd0);
        Reset = 1'b1;
        repeat (20) @(posedge Clk);

        // 1: make / break of W
        sb.push_back(16'h001A); send_byte(8'h1D, 1'b0);
        step_done("t1_make", 16'h001A);
        sb.push_back(16'h0000); send_byte(8'hF0, 1'b0); send_byte(8'h1D, 1'b0);
        step_done("t1_break", 16'h0000);

        // 2: extended Up, then unmapped keypad 2
        sb.push_back(16'h0052); send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
        step_done("t2_make", 16'h0052);
        sb.push_back(16'h0000); send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
        step_done("t2_break", 16'h0000);
        send_byte(8'h72, 1'b0);
        step_done("t2_kp2", 16'h0000);

        // 3: last make wins, break of other key ignored
        sb.push_back(16'h001A); send_byte(8'h1D, 1'b0);
        sb.push_back(16'h0004); send_byte(8'h1C, 1'b0);
        step_done("t3_make2", 16'h0004);
        send_byte(8'hF0, 1'b0); send_byte(8'h1D, 1'b0);
        step_done("t3_brk_other", 16'h0004);
        sb.push_back(16'h0000); send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
        step_done("t3_brk_held", 16'h0000);

        // 4: typematic repeats give one pulse
        sb.push_back(16'h001A);
        for (int i = 0; i < 3; i++) send_byte(8'h1D, 1'b0);
        step_done("t4_typematic", 16'h001A);
        sb.push_back(16'h0000); send_byte(8'hF0, 1'b0); send_byte(8'h1D, 1'b0);
        step_done("t4_release", 16'h0000);

        // 5: parity error, then recovery
        err_exp++; send_byte(8'h1D, 1'b1);
        step_done("t5_par_err", 16'h0000);
        sb.push_back(16'h0004); send_byte(8'h1C, 1'b0);
        step_done("t5_recover", 16'h0004);

        // 6a: stall after 5 data bits
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        err_exp++;
        repeat (2 * TO_CYC) @(posedge Clk);
        step_done("t6_timeout", 16'h0004);

        // 6b: 3-cycle clock glitch with data low must not start a frame
        ps2_data = 1'b0;
        repeat (5) @(posedge Clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge Clk);
        ps2_clk = 1'b1;
        repeat (20) @(posedge Clk);
        ps2_data = 1'b1;
        repeat (2 * TO_CYC) @(posedge Clk);
        step_done("t6_glitch", 16'h0004);
        sb.push_back(16'h0000); send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
        step_done("t6_after_glitch", 16'h0000);

        // 6c: reset mid-frame
        sb.push_back(16'h001A); send_byte(8'h1D, 1'b0);
        step_done("t6_pre_rst", 16'h001A);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        check("rst_mid_keycode", {16'd0, kbd.keycode}, 32'd0);
        check("rst_mid_valid", {31'd0, kbd.key_valid}, 32'd0);
        check("rst_mid_err", {31'd0, kbd.frame_err}, 32'd0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(posedge Clk);
        #1 Reset = 1'b1;
        repeat (2 * TO_CYC) @(posedge Clk);
        step_done("t6_post_rst", 16'h0000);
        sb.push_back(16'h0004); send_byte(8'h1C, 1'b0);
        step_done("t6_rst_recover", 16'h0004);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
